// File: rtl/decode_regfile_stage_if.sv
// Handshake and operand bus between fetch, writeback and the decode/register-read stage.
// The slave modport is the stage side, and the master modport is the upstream/ALU side.
interface decode_regfile_stage_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  OPCode;
    logic [31:0] Rs;
    logic [31:0] Rt;
    logic [31:0] Immediate;
    logic [4:0]  dest_addr;

    modport master (
        output instr_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        input  instr_ready, out_valid, OPCode, Rs, Rt, Immediate, dest_addr
    );

    modport slave (
        input  instr_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        output instr_ready, out_valid, OPCode, Rs, Rt, Immediate, dest_addr
    );
endinterface

// File: rtl/decode_regfile_stage.sv
// I-type decode and register-read stage with a per-register pending scoreboard.
// Optional macro RF_BYPASS_EN: a same-cycle writeback forwards into reads and clears the stall.
module decode_regfile_stage (
    input  logic                         clk,
    input  logic                         rst,
    decode_regfile_stage_if.slave        bus
);
    localparam int RF_DEPTH = 32;

    function automatic logic isWriting(input logic [5:0] op);
        case (op)
            6'b001000, 6'b001001, 6'b001100, 6'b001101,
            6'b001111, 6'b001010, 6'b001011, 6'b100011: isWriting = 1'b1;
            default:                                    isWriting = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extendImm(input logic [5:0] op, input logic [15:0] imm);
        case (op)
            6'b001100, 6'b001101: extendImm = {16'h0000, imm};
            6'b001111:            extendImm = {imm, 16'h0000};
            default:              extendImm = {{16{imm[15]}}, imm};
        endcase
    endfunction

    logic [31:0] regFileR [RF_DEPTH];
    logic [31:0] pendingR;
    logic [31:0] pendingNextS;
    logic        outValidR;
    logic [5:0]  opCodeR;
    logic [31:0] rsValR;
    logic [31:0] rtValR;
    logic [31:0] immR;
    logic [4:0]  destR;

    logic [5:0]  opcodeS;
    logic [4:0]  rsAddrS;
    logic [4:0]  rtAddrS;
    logic        writingS;
    logic        rsPendS;
    logic        rtPendS;
    logic        stallS;
    logic        readyS;
    logic        acceptS;
    logic [31:0] rsDataS;
    logic [31:0] rtDataS;

    assign opcodeS  = bus.instr[31:26];
    assign rsAddrS  = bus.instr[25:21];
    assign rtAddrS  = bus.instr[20:16];
    assign writingS = isWriting(opcodeS);

    // Effective pending bits for rs/rt, optionally discounting a same-cycle writeback.
    always_comb begin
        rsPendS = pendingR[rsAddrS];
        rtPendS = pendingR[rtAddrS];
`ifdef RF_BYPASS_EN
        if (bus.wb_en && (bus.wb_addr == rsAddrS)) begin
            rsPendS = 1'b0;
        end else begin
            rsPendS = pendingR[rsAddrS];
        end
        if (bus.wb_en && (bus.wb_addr == rtAddrS)) begin
            rtPendS = 1'b0;
        end else begin
            rtPendS = pendingR[rtAddrS];
        end
`endif
    end

    // Every opcode is either writing or rt-reading, so both keep rt in the hazard check.
    assign stallS  = rsPendS | (!writingS & rtPendS) | (writingS & rtPendS);
    assign readyS  = !rst & !stallS & (!outValidR | bus.out_ready);
    assign acceptS = bus.instr_valid & readyS;

    // Register read with r0 hardwired to zero.
    always_comb begin
        rsDataS = 32'h0000_0000;
        rtDataS = 32'h0000_0000;
        if (rsAddrS == 5'd0) begin
            rsDataS = 32'h0000_0000;
`ifdef RF_BYPASS_EN
        end else if (bus.wb_en && (bus.wb_addr == rsAddrS)) begin
            rsDataS = bus.wb_data;
`endif
        end else begin
            rsDataS = regFileR[rsAddrS];
        end
        if (rtAddrS == 5'd0) begin
            rtDataS = 32'h0000_0000;
`ifdef RF_BYPASS_EN
        end else if (bus.wb_en && (bus.wb_addr == rtAddrS)) begin
            rtDataS = bus.wb_data;
`endif
        end else begin
            rtDataS = regFileR[rtAddrS];
        end
    end

    // Scoreboard next state: writeback clears first so a same-cycle set wins.
    always_comb begin
        pendingNextS = pendingR;
        if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
            pendingNextS[bus.wb_addr] = 1'b0;
        end else begin
            pendingNextS[0] = 1'b0;
        end
        if (acceptS && writingS && (rtAddrS != 5'd0)) begin
            pendingNextS[rtAddrS] = 1'b1;
        end else begin
            pendingNextS[0] = 1'b0;
        end
        pendingNextS[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendingR <= 32'h0000_0000;
        end else begin
            pendingR <= pendingNextS;
        end
    end

    // Register file write port; r0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regFileR[i] <= 32'h0000_0000;
            end
        end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
            regFileR[bus.wb_addr] <= bus.wb_data;
        end else begin
            regFileR[0] <= 32'h0000_0000;
        end
    end

    // One-entry operand register toward the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValidR <= 1'b0;
            opCodeR   <= 6'd0;
            rsValR    <= 32'h0000_0000;
            rtValR    <= 32'h0000_0000;
            immR      <= 32'h0000_0000;
            destR     <= 5'd0;
        end else if (acceptS) begin
            outValidR <= 1'b1;
            opCodeR   <= opcodeS;
            rsValR    <= rsDataS;
            rtValR    <= rtDataS;
            immR      <= extendImm(opcodeS, bus.instr[15:0]);
            destR     <= writingS ? rtAddrS : 5'd0;
        end else if (bus.out_ready) begin
            outValidR <= 1'b0;
        end else begin
            outValidR <= outValidR;
        end
    end

    assign bus.instr_ready = readyS;
    assign bus.out_valid   = outValidR;
    assign bus.OPCode      = opCodeR;
    assign bus.Rs          = rsValR;
    assign bus.Rt          = rtValR;
    assign bus.Immediate   = immR;
    assign bus.dest_addr   = destR;
endmodule

// File: tb/tb_decode_regfile_stage.sv
// Scoreboard bench for decode_regfile_stage: directed vectors push expected operands and a
// negedge monitor compares them whenever the stage hands operands to the ALU.
module tb_decode_regfile_stage;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  dest;
    } exp_t;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    exp_t sb[$];
    exp_t monE;

    decode_regfile_stage_if bus();

    decode_regfile_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        mk = {op, rs, rt, imm};
    endfunction

    function automatic exp_t mkExp(input logic [5:0] op, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [31:0] imm,
                                   input logic [4:0] dest);
        mkExp = '{op: op, rs: rs, rt: rt, imm: imm, dest: dest};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        testsRun++;
        if (act !== expv) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: each operand handoff to the ALU is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("FAIL unexpected_output: got OPCode 0x%02h expected no output", bus.OPCode);
            end else begin
                monE = sb.pop_front();
                chk("mon_opcode", {26'h0, bus.OPCode}, {26'h0, monE.op});
                chk("mon_rs", bus.Rs, monE.rs);
                chk("mon_rt", bus.Rt, monE.rt);
                chk("mon_imm", bus.Immediate, monE.imm);
                chk("mon_dest", {27'h0, bus.dest_addr}, {27'h0, monE.dest});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input exp_t e, input bit mustBeReady);
        bit done;
        done = 1'b0;
        bus.instr = w;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (i == 0 && mustBeReady) chk("ready_now", {31'h0, bus.instr_ready}, 32'h1);
            if (bus.instr_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            cyc();
        end
        bus.instr_valid = 1'b0;
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    // Dependent instruction: must stall until writeback of wbA, then be accepted.
    task automatic sendDep(input logic [31:0] w, input exp_t e,
                           input logic [4:0] wbA, input logic [31:0] wbD);
        bus.instr = w;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("dep_stall", {31'h0, bus.instr_ready}, 32'h0);
            cyc();
        end
        bus.wb_en = 1'b1;
        bus.wb_addr = wbA;
        bus.wb_data = wbD;
        @(negedge clk);
`ifdef RF_BYPASS_EN
        chk("dep_bypass_ready", {31'h0, bus.instr_ready}, 32'h1);
        sb.push_back(e);
        cyc();
        bus.wb_en = 1'b0;
`else
        chk("dep_wb_cycle_stall", {31'h0, bus.instr_ready}, 32'h0);
        cyc();
        bus.wb_en = 1'b0;
        @(negedge clk);
        chk("dep_after_wb_ready", {31'h0, bus.instr_ready}, 32'h1);
        sb.push_back(e);
        cyc();
`endif
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        testsRun = 0;
        testsFailed = 0;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 32'h0;
        bus.wb_en = 1'b0;
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'h0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_ready", {31'h0, bus.instr_ready}, 32'h0);
        chk("rst_opcode", {26'h0, bus.OPCode}, 32'h0);
        chk("rst_rs", bus.Rs, 32'h0);
        chk("rst_imm", bus.Immediate, 32'h0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, bus.instr_ready}, 32'h1);

        // r5 = 0x10, then ADDI rs=5 rt=6 imm=0xFFFF
        cyc();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_0010;
        cyc();
        bus.wb_en = 1'b0;
        send(mk(OP_ADDI, 5'd5, 5'd6, 16'hFFFF), mkExp(OP_ADDI, 32'h10, 32'h0, 32'hFFFF_FFFF, 5'd6), 1'b1);
        // pending[6] shows as a stall on an rs=6 reader
        sendDep(mk(OP_ORI, 5'd6, 5'd0, 16'h0001), mkExp(OP_ORI, 32'h55, 32'h0, 32'h0000_0001, 5'd0), 5'd6, 32'h55);

        // Immediate extension with 0x8001
        send(mk(OP_ORI,   5'd5, 5'd0, 16'h8001), mkExp(OP_ORI,   32'h10, 32'h0, 32'h0000_8001, 5'd0), 1'b1);
        send(mk(OP_LUI,   5'd5, 5'd0, 16'h8001), mkExp(OP_LUI,   32'h10, 32'h0, 32'h8001_0000, 5'd0), 1'b1);
        send(mk(OP_SLTIU, 5'd5, 5'd0, 16'h8001), mkExp(OP_SLTIU, 32'h10, 32'h0, 32'hFFFF_8001, 5'd0), 1'b1);
        send(mk(OP_ANDI,  5'd5, 5'd0, 16'h8001), mkExp(OP_ANDI,  32'h10, 32'h0, 32'h0000_8001, 5'd0), 1'b1);
        send(mk(OP_BEQ,   5'd5, 5'd5, 16'h8001), mkExp(OP_BEQ,   32'h10, 32'h10, 32'hFFFF_8001, 5'd0), 1'b1);

        // RAW: ADDI rt=7 then BEQ rs=7
        send(mk(OP_ADDI, 5'd0, 5'd7, 16'h0001), mkExp(OP_ADDI, 32'h0, 32'h0, 32'h1, 5'd7), 1'b1);
        sendDep(mk(OP_BEQ, 5'd7, 5'd0, 16'h0004), mkExp(OP_BEQ, 32'h1234, 32'h0, 32'h4, 5'd0), 5'd7, 32'h1234);

        // Back-pressure
        cyc();
        bus.out_ready = 1'b0;
        send(mk(OP_ADDIU, 5'd5, 5'd0, 16'h0002), mkExp(OP_ADDIU, 32'h10, 32'h0, 32'h2, 5'd0), 1'b1);
        bus.instr = mk(OP_ORI, 5'd5, 5'd0, 16'h0003);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", {31'h0, bus.instr_ready}, 32'h0);
            chk("bp_valid", {31'h0, bus.out_valid}, 32'h1);
            chk("bp_opcode", {26'h0, bus.OPCode}, {26'h0, OP_ADDIU});
            chk("bp_rs", bus.Rs, 32'h10);
            chk("bp_imm", bus.Immediate, 32'h2);
            cyc();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'h0, bus.instr_ready}, 32'h1);
        sb.push_back(mkExp(OP_ORI, 32'h10, 32'h0, 32'h3, 5'd0));
        cyc();
        bus.instr_valid = 1'b0;

        // WAW: LW rt=3 then ADDI rt=3
        send(mk(OP_LW, 5'd0, 5'd3, 16'h0010), mkExp(OP_LW, 32'h0, 32'h0, 32'h10, 5'd3), 1'b1);
        sendDep(mk(OP_ADDI, 5'd0, 5'd3, 16'h0005), mkExp(OP_ADDI, 32'h0, 32'h77, 32'h5, 5'd3), 5'd3, 32'h77);

        // r0: never pending, writes ignored
        send(mk(OP_ADDI, 5'd0, 5'd0, 16'h0009), mkExp(OP_ADDI, 32'h0, 32'h0, 32'h9, 5'd0), 1'b1);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h0000_DEAD;
        send(mk(OP_BEQ, 5'd0, 5'd0, 16'h0000), mkExp(OP_BEQ, 32'h0, 32'h0, 32'h0, 5'd0), 1'b1);
        bus.wb_en = 1'b0;
        send(mk(OP_ADDIU, 5'd0, 5'd0, 16'h0000), mkExp(OP_ADDIU, 32'h0, 32'h0, 32'h0, 5'd0), 1'b1);

        // Asynchronous reset with out_valid=1 and pending[4]=1
        cyc();
        bus.out_ready = 1'b0;
        send(mk(OP_ADDI, 5'd0, 5'd4, 16'h0001), mkExp(OP_ADDI, 32'h0, 32'h0, 32'h1, 5'd4), 1'b1);
        chk("pre_rst_valid", {31'h0, bus.out_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("async_rst_opcode", {26'h0, bus.OPCode}, 32'h0);
        chk("async_rst_dest", {27'h0, bus.dest_addr}, 32'h0);
        sb.delete();
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(mk(OP_BEQ, 5'd5, 5'd4, 16'h0000), mkExp(OP_BEQ, 32'h0, 32'h0, 32'h0, 5'd0), 1'b1);
        send(mk(OP_ADDI, 5'd3, 5'd0, 16'h0000), mkExp(OP_ADDI, 32'h0, 32'h0, 32'h0, 5'd0), 1'b1);

        cyc();
        cyc();
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
